seq_logic_unit: RTL and testbench
=================================

# seq_logic_unit

Parametrised, multi-cycle bitwise logic unit for the ULA datapath. It generalises the fixed-width OR slice to any multiple-of-slice width and adds selectable operations. Operands are processed one SLICE-bit slice per clock, least significant slice first, under a start/busy/done handshake. The registered result and zero flag stay stable between operations.

## Interface
- WIDTH, 8: operand/result width; must be a positive multiple of SLICE.
- SLICE, 4: bits processed per clock; NSLICE = WIDTH/SLICE.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 pass A.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; ignored for op 011 and 111.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; Result and zero are valid from this cycle.
- Result  out  WIDTH  registered result.
- zero  out  1  registered; 1 when Result == 0.

## Operation
- One clock domain. Reset is synchronous and active-high.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If start=1 at an edge, latch A, B and op into internal registers.
  - Clear the working accumulator and set the slice index idx to 0.
  - Go to RUN.
- RUN:
  - Each edge computes op on latched slice [idx*SLICE +: SLICE] and writes it into the same accumulator slice.
  - If idx == NSLICE-1 at that edge, go to DONE. Otherwise idx increments.
  - idx width is clog2(NSLICE), minimum 1 bit. idx never wraps past NSLICE-1.
- DONE:
  - Hold for exactly one cycle with done=1.
  - Result and zero are loaded from the accumulator on the edge that enters DONE.
  - The next edge returns to IDLE.
- start is ignored in RUN and DONE: no queueing and no restart.
- Inputs A, B and op may change freely after the start edge. Only the latched copies are used.
- Result and zero hold their last values until the next DONE load. They never show partial results.
- Operations are purely bitwise: no carries, no cross-slice dependency. Every bit of Result equals op applied to the same bit of A and B.
- NSLICE = 1 is legal: RUN lasts one cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, Result 0, zero 1, idx 0.
- Reset values of the internal latches: accumulator 0, latched operands 0.
- Edge E0 samples start=1 in IDLE:
  - busy goes high after E0.
  - Slices are processed at E1..E_NSLICE.
  - done=1, plus the new Result and zero, in the cycle after E_NSLICE.
  - busy drops after E_NSLICE+1.
- Latency from the start edge to done is NSLICE cycles. The next start can be accepted at E_NSLICE+2, so throughput is one operation per NSLICE+2 cycles.
- rst=1 at any edge overrides everything, including a simultaneous start:
  - Return to IDLE with the reset values above.
  - No done pulse is emitted for an aborted operation.
- start held high continuously starts a new operation every time IDLE is re-entered.

## Test plan
- WIDTH=8, op=001, A=0xA5, B=0x0F, start for one cycle:
  - done pulses exactly 2 cycles after the start edge, for one cycle.
  - Result=0xAF, zero=0.
- WIDTH=8, op=000, A=0xF0, B=0x0F: Result=0x00, zero=1.
- Same configuration, then op=010, A=0xFF, B=0x3C: Result=0xC3, zero=0.
- WIDTH=16, op=101 (NOR), A=0x00FF, B=0x0F00:
  - done 4 cycles after the start edge.
  - Result=0xF000.
  - Result keeps its previous value during RUN.
- WIDTH=8, op=001, A=0x01, B=0x02, start accepted:
  - During RUN, drive A=0xFF, op=000 and pulse start.
  - Result=0x03 with a single done pulse. The second start is ignored.
- WIDTH=16, op=001, A=0x1234, B=0x0000, start accepted:
  - Assert rst for one cycle two edges after the start edge.
  - No done pulse; busy=0, Result=0, zero=1.
  - A new op=111 with A=0x1234 then completes normally with Result=0x1234.

Source files
------------

// File: rtl/seq_logic_unit.sv
// rtl/seq_logic_unit.sv - multi-cycle bitwise logic unit, one SLICE-bit slice per clock
module seq_logic_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [1:0]       state_q,  state_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       op_q,     op_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_res;
    int               slice_base;

    function automatic logic [SLICE-1:0] apply_op(
        input logic [2:0]       o,
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y
    );
        logic [SLICE-1:0] r;
        case (o)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOTA: r = ~x;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_PASS: r = x;
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        slice_base = int'(idx_q) * SLICE;
        slice_a    = a_q[slice_base +: SLICE];
        slice_b    = b_q[slice_base +: SLICE];
        slice_res  = apply_op(op_q, slice_a, slice_b);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[slice_base +: SLICE] = slice_res;
                if (idx_q == IDX_LAST) begin
                    // Load from the updated accumulator so the final slice is included.
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign Result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// tb/tb_seq_logic_unit.sv - scoreboard bench for seq_logic_unit at WIDTH 8 and 16
module tb_seq_logic_unit;

    logic clk;
    logic rst;

    logic        start8, busy8, done8, zero8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, r8;

    logic        start16, busy16, done16, zero16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, r16;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp8_q[$];
    logic [15:0] exp16_q[$];

    seq_logic_unit #(.WIDTH(8), .SLICE(4)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Result(r8), .zero(zero8)
    );

    seq_logic_unit #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .Result(r16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e);
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        exp8_q.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic go16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e);
        op16 = o; a16 = a; b16 = b; start16 = 1'b1;
        exp16_q.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_done16(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
        op8 = 3'b111; a8 = 8'h5A; b8 = 8'h00;
        op16 = 3'b111; a16 = 16'h5A5A; b16 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0 || busy16 !== 1'b0) begin
            $display("FAIL reset_busy: got %b/%b want 0/0", busy8, busy16);
            bad++;
        end
        total++; if (done8 !== 1'b0 || done16 !== 1'b0) begin
            $display("FAIL reset_done: got %b/%b want 0/0", done8, done16);
            bad++;
        end
        total++; if (r8 !== 8'h00 || r16 !== 16'h0000) begin
            $display("FAIL reset_result: got %h/%h want 00/0000", r8, r16);
            bad++;
        end
        total++; if (zero8 !== 1'b1 || zero16 !== 1'b1) begin
            $display("FAIL reset_zero: got %b/%b want 1/1", zero8, zero16);
            bad++;
        end
        start8 = 1'b0; start16 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy8 !== 1'b0) begin
            $display("FAIL reset_idle_after: busy got %b want 0", busy8);
            bad++;
        end
    endtask

    task automatic test_or8;
        int cyc;
        logic [7:0] e;
        go8(3'b001, 8'hA5, 8'h0F, 8'hAF);
        total++; if (busy8 !== 1'b1) begin
            $display("FAIL or8_busy_after_start: got %b want 1", busy8);
            bad++;
        end
        total++; if (r8 !== 8'h00) begin
            $display("FAIL or8_result_held_run: got %h want 00", r8);
            bad++;
        end
        wait_done8(cyc);
        total++; if (cyc != 2) begin
            $display("FAIL or8_latency: got %0d want 2", cyc);
            bad++;
        end
        e = exp8_q.pop_front();
        total++; if (r8 !== e) begin
            $display("FAIL or8_result: got %h want %h", r8, e);
            bad++;
        end
        total++; if (zero8 !== (e == 8'h00)) begin
            $display("FAIL or8_zero: got %b want %b", zero8, (e == 8'h00));
            bad++;
        end
        @(posedge clk); #1;
        total++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            $display("FAIL or8_done_one_cycle: done=%b busy=%b want 0/0", done8, busy8);
            bad++;
        end
        total++; if (r8 !== e) begin
            $display("FAIL or8_result_stable: got %h want %h", r8, e);
            bad++;
        end
    endtask

    task automatic test_and_xor8;
        int cyc;
        logic [7:0] e;
        go8(3'b000, 8'hF0, 8'h0F, 8'h00);
        wait_done8(cyc);
        e = exp8_q.pop_front();
        total++; if (cyc != 2 || r8 !== e || zero8 !== 1'b1) begin
            $display("FAIL and8: cyc=%0d result=%h zero=%b want 2/%h/1", cyc, r8, zero8, e);
            bad++;
        end
        @(posedge clk); #1;
        go8(3'b010, 8'hFF, 8'h3C, 8'hC3);
        wait_done8(cyc);
        e = exp8_q.pop_front();
        total++; if (cyc != 2 || r8 !== e || zero8 !== 1'b0) begin
            $display("FAIL xor8: cyc=%0d result=%h zero=%b want 2/%h/0", cyc, r8, zero8, e);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_all_ops8;
        int cyc;
        logic [7:0] a, b, e;
        logic [7:0] ops_a;
        ops_a = 8'h6C;
        b = 8'hA9;
        for (int o = 0; o < 8; o++) begin
            a = ops_a ^ 8'(o);
            case (o)
                0: e = a & b;
                1: e = a | b;
                2: e = a ^ b;
                3: e = ~a;
                4: e = ~(a & b);
                5: e = ~(a | b);
                6: e = ~(a ^ b);
                default: e = a;
            endcase
            go8(3'(o), a, b, e);
            a8 = ~a8; b8 = ~b8; op8 = ~op8;
            wait_done8(cyc);
            e = exp8_q.pop_front();
            total++; if (cyc != 2 || r8 !== e || zero8 !== (e == 8'h00)) begin
                $display("FAIL op8_%0d: cyc=%0d result=%h zero=%b want 2/%h/%b",
                         o, cyc, r8, zero8, e, (e == 8'h00));
                bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nor16;
        int cyc;
        int held_bad;
        logic [15:0] e;
        go16(3'b111, 16'hBEEF, 16'h1111, 16'hBEEF);
        wait_done16(cyc);
        e = exp16_q.pop_front();
        total++; if (cyc != 4 || r16 !== e) begin
            $display("FAIL pass16: cyc=%0d result=%h want 4/%h", cyc, r16, e);
            bad++;
        end
        @(posedge clk); #1;
        go16(3'b101, 16'h00FF, 16'h0F00, 16'hF000);
        held_bad = 0;
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!done16 && r16 !== 16'hBEEF) held_bad++;
            @(posedge clk); #1;
            if (done16) begin
                cyc = k;
                break;
            end
        end
        total++; if (held_bad != 0) begin
            $display("FAIL nor16_result_held: %0d run cycles changed Result, want 0", held_bad);
            bad++;
        end
        e = exp16_q.pop_front();
        total++; if (cyc != 4) begin
            $display("FAIL nor16_latency: got %0d want 4", cyc);
            bad++;
        end
        total++; if (r16 !== e || zero16 !== 1'b0) begin
            $display("FAIL nor16_result: got %h zero=%b want %h/0", r16, zero16, e);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start8;
        int pulses;
        logic [7:0] e;
        go8(3'b001, 8'h01, 8'h02, 8'h03);
        a8 = 8'hFF; op8 = 3'b000; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        pulses = 0;
        e = 8'hxx;
        for (int k = 0; k < 10; k++) begin
            if (done8) begin
                pulses++;
                e = exp8_q.pop_front();
                total++; if (r8 !== e) begin
                    $display("FAIL ignore8_result: got %h want %h", r8, e);
                    bad++;
                end
            end
            @(posedge clk); #1;
        end
        total++; if (pulses != 1) begin
            $display("FAIL ignore8_pulses: got %0d want 1", pulses);
            bad++;
        end
    endtask

    task automatic test_abort16;
        int pulses;
        int cyc;
        logic [15:0] e;
        go16(3'b001, 16'h1234, 16'h0000, 16'h1234);
        void'(exp16_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy16 !== 1'b0 || r16 !== 16'h0000 || zero16 !== 1'b1) begin
            $display("FAIL abort16_state: busy=%b result=%h zero=%b want 0/0000/1",
                     busy16, r16, zero16);
            bad++;
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (done16) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses != 0) begin
            $display("FAIL abort16_no_done: got %0d pulses want 0", pulses);
            bad++;
        end
        go16(3'b111, 16'h1234, 16'hFFFF, 16'h1234);
        wait_done16(cyc);
        e = exp16_q.pop_front();
        total++; if (cyc != 4 || r16 !== e || zero16 !== 1'b0) begin
            $display("FAIL abort16_recover: cyc=%0d result=%h zero=%b want 4/%h/0",
                     cyc, r16, zero16, e);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        logic [7:0] e;
        op8 = 3'b010; a8 = 8'h55; b8 = 8'hFF; start8 = 1'b1;
        exp8_q.push_back(8'hAA);
        @(posedge clk); #1;
        wait_done8(t1);
        e = exp8_q.pop_front();
        total++; if (t1 != 2 || r8 !== e) begin
            $display("FAIL b2b_first: cyc=%0d result=%h want 2/%h", t1, r8, e);
            bad++;
        end
        a8 = 8'h0F;
        exp8_q.push_back(8'hF0);
        wait_done8(t2);
        start8 = 1'b0;
        e = exp8_q.pop_front();
        total++; if (t2 != 4) begin
            $display("FAIL b2b_interval: got %0d want 4", t2);
            bad++;
        end
        total++; if (r8 !== e || zero8 !== 1'b0) begin
            $display("FAIL b2b_second: result=%h zero=%b want %h/0", r8, zero8, e);
            bad++;
        end
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0 || exp8_q.size() != 0) begin
            $display("FAIL b2b_drain: busy=%b queue=%0d want 0/0", busy8, exp8_q.size());
            bad++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_or8();
        test_and_xor8();
        test_all_ops8();
        test_nor16();
        test_ignore_start8();
        test_abort16();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
